// File: rtl/saturn_debug_pkg.sv
// Purpose : shared types and constants for the Saturn debug UART path.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
//
// Contents: transmitter FSM state encoding, 8N1 frame constants, default
// baud divisor, and a helper that sizes the baud counter.

package saturn_debug_pkg;

    // Transmitter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // 8N1 framing.
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    // 12 MHz / 115200 baud.
    localparam int DEFAULT_CLK_PER_BIT = 104;

    // Width of a down-counter that must hold clk_per_bit-1.
    // Never narrower than one bit so the smallest legal divisor (2) still works.
    function automatic int cnt_width(input int clk_per_bit);
        if (clk_per_bit <= 2) begin
            return 1;
        end
        return $clog2(clk_per_bit);
    endfunction

endpackage

// File: rtl/saturn_debug_fifo.sv
// Purpose : generic synchronous FIFO, data out is the current head entry.
// Latency : push visible at the head one cycle after the write edge.
// Backpr. : o_full refuses pushes; pops on an empty FIFO are ignored.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset (empties FIFO)
//   i_push, i_push_dat  write request and data (ignored while full)
//   i_pop               remove head entry (ignored while empty)
//   o_head              current head entry (valid when !o_empty)
//   o_full, o_empty     status, combinational from the pointers
//   o_level             registered entry count, 0..2**FIFO_AW

module saturn_debug_fifo #(
    parameter int FIFO_AW = 4,
    parameter int DW      = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  logic [DW-1:0]      i_push_dat,
    input  logic               i_pop,
    output logic [DW-1:0]      o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic [FIFO_AW:0]   o_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);

    generate
        if (FIFO_AW < 1) begin : g_bad_aw
            $error("saturn_debug_fifo: FIFO_AW must be at least 1");
        end
    endgenerate

    logic [DW-1:0]    mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal means empty, equal low bits
    // with differing wrap bits means full.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    // Fullness is judged on the state at the start of the cycle, so a
    // simultaneous pop never frees a slot for a same-cycle push.
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + PTR_ONE;
            2'b01:   level_d = level_q - PTR_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: nothing is read until a push has landed.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= i_push_dat;
        end
    end

    assign o_head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign o_level = level_q;

endmodule

// File: rtl/saturn_debug_uart_tx.sv
// Purpose : 8N1 UART transmitter for the bus controller's debug char stream.
// Latency : push into empty idle FIFO at edge N -> start bit on o_tx at N+2.
// Backpr. : o_char_ready = !fifo_full; chars offered while full are dropped
//           and latch the sticky o_overflow flag.
//
// Ports:
//   i_clk, i_reset          raw system clock, synchronous active-high reset
//   i_char, i_char_valid    character in (accepted when o_char_ready)
//   o_char_ready            FIFO not full (combinational)
//   o_tx                    UART line, idle high (registered)
//   o_busy                  frame in progress or chars queued (combinational)
//   o_overflow              sticky dropped-character flag (registered)
//   o_fifo_level            queued chars, excluding the one being shifted

module saturn_debug_uart_tx
    import saturn_debug_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_AW     = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_char,
    input  logic               i_char_valid,
    output logic               o_char_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [FIFO_AW:0]   o_fifo_level
);

    localparam int CNT_W = cnt_width(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

    generate
        if (CLK_PER_BIT < 2) begin : g_bad_cpb
            $error("saturn_debug_uart_tx: CLK_PER_BIT must be 2 or more");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Character queue
    // ------------------------------------------------------------------
    logic               fifo_push;
    logic               fifo_pop;
    logic [7:0]         fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_level;

    assign fifo_push = i_char_valid && !fifo_full;

    saturn_debug_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (8)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (fifo_push),
        .i_push_dat (i_char),
        .i_pop      (fifo_pop),
        .o_head     (fifo_head),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty),
        .o_level    (fifo_level)
    );

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               overflow_q, overflow_d;
    logic               cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (i_char_valid & fifo_full);

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    cnt_d    = CNT_RELOAD;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                if (cnt_zero) begin
                    cnt_d     = CNT_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_zero) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    cnt_d     = CNT_RELOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_zero) begin
                    // Chain straight into the next start bit when more
                    // characters are waiting, so frames run back-to-back.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        cnt_d    = CNT_RELOAD;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The line is a registered image of the current state, so it trails the
    // FSM by one cycle; every bit window keeps its full CLK_PER_BIT width.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_tx         = tx_q;
    assign o_overflow   = overflow_q;
    assign o_fifo_level = fifo_level;
    assign o_char_ready = !fifo_full;
    assign o_busy       = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_saturn_debug_uart_tx.sv
module tb_saturn_debug_uart_tx;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  ch = 8'd0;
    logic        o_char_ready;
    logic        o_tx;
    logic        o_busy;
    logic        o_overflow;
    logic [AW:0] o_fifo_level;

    always #5 clk = ~clk;

    saturn_debug_uart_tx #(
        .CLK_PER_BIT (CPB),
        .FIFO_AW     (AW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_char       (ch),
        .i_char_valid (valid),
        .o_char_ready (o_char_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_fifo_level (o_fifo_level)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of waiting characters plus a countdown of
    // how long the serializer stays occupied by the frame it owns. A new
    // frame may begin when the serializer is free or in its final cycle.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    logic [7:0] exp_tx[$];
    int         ser_left = 0;
    bit         m_ovf = 1'b0;
    bit         m_pop;
    bit         m_acc;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_q.delete();
                exp_tx.delete();
                ser_left = 0;
                m_ovf    = 1'b0;
            end else begin
                m_pop = (m_q.size() != 0) && (ser_left <= 1);
                m_acc = valid && (m_q.size() < DEPTH);
                if (valid && !m_acc) m_ovf = 1'b1;
                if (m_pop) begin
                    void'(m_q.pop_front());
                    ser_left = FRAME;
                end else if (ser_left > 0) begin
                    ser_left--;
                end
                if (m_acc) begin
                    m_q.push_back(ch);
                    exp_tx.push_back(ch);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison and line decoder (sampled on the falling edge).
    // ------------------------------------------------------------------
    logic [7:0] rx_byte_q[$];
    logic [9:0] rx_bits_q[$];
    int         rx_start_q[$];
    bit         dec_act = 1'b0;
    int         dec_start = 0;
    int         off;
    logic [9:0] dec_bits = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_level", o_fifo_level, m_q.size());
                chk("cyc_ready", o_char_ready, m_q.size() < DEPTH);
                chk("cyc_overflow", o_overflow, m_ovf);
                chk("cyc_busy", o_busy, (ser_left != 0) || (m_q.size() != 0));
                if (ser_left == 0) chk("cyc_tx_idle", o_tx, 1);
            end
            if (rst || !chk_en) begin
                dec_act = 1'b0;
            end else begin
                if (!dec_act && o_tx === 1'b0) begin
                    dec_act   = 1'b1;
                    dec_start = cyc;
                end
                if (dec_act) begin
                    off = cyc - dec_start;
                    if (off % CPB == CPB / 2) dec_bits[off / CPB] = o_tx;
                    if (off == 9 * CPB + CPB / 2) begin
                        dec_act = 1'b0;
                        rx_bits_q.push_back(dec_bits);
                        rx_byte_q.push_back(dec_bits[8:1]);
                        rx_start_q.push_back(dec_start);
                        chk("frame_start_bit", dec_bits[0], 0);
                        chk("frame_stop_bit", dec_bits[9], 1);
                        chk("frame_expected", exp_tx.size() != 0, 1);
                        if (exp_tx.size() != 0) chk("frame_byte", dec_bits[8:1], exp_tx.pop_front());
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int bound);
        int n = 0;
        while (rx_byte_q.size() < target && n < bound) begin
            step();
            n++;
        end
        chk("frames_timeout", rx_byte_q.size() >= target, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((o_busy || dec_act) && n < bound) begin
            step();
            n++;
        end
        chk("idle_timeout", o_busy, 0);
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        int         exp_level;
        bit         exp_ready;
        bit         exp_ovf;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] pp_exp[4];

    initial begin
        int r0;
        int n;
        int p;
        int zeros;

        // FIFO of 4 behind a busy serializer: first char goes straight to
        // the shifter, four fill the queue, the sixth is refused.
        tbl[0] = '{1'b1, 8'hC0, 1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'hC1, 1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'hC2, 2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'hC3, 3, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'hC4, 4, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'hC5, 4, 1'b0, 1'b1};
        pp_exp[0] = 8'h11;
        pp_exp[1] = 8'h22;
        pp_exp[2] = 8'h33;
        pp_exp[3] = 8'h44;

        // Reset and idle line.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_char_ready, 1);
        chk("rst_level", o_fifo_level, 0);
        chk("rst_overflow", o_overflow, 0);
        zeros = 0;
        repeat (100) begin
            step();
            if (o_tx !== 1'b1) zeros++;
        end
        chk("idle_tx_100", zeros, 0);

        // Single character 0x41.
        r0 = rx_byte_q.size();
        valid = 1'b1;
        ch = 8'h41;
        step();
        n = cyc;
        valid = 1'b0;
        repeat (40) step();
        chk("single_busy_end", o_busy, 1);
        repeat (2) step();
        chk("single_frames", rx_byte_q.size(), r0 + 1);
        chk("single_busy_after", o_busy, 0);
        if (rx_byte_q.size() > r0) begin
            chk("single_fall_latency", rx_start_q[r0] - n, 2);
            chk("single_bits", rx_bits_q[r0], 10'b1010000010);
        end

        // Back-to-back frames.
        r0 = rx_byte_q.size();
        valid = 1'b1;
        ch = 8'h55;
        step();
        ch = 8'hAA;
        step();
        valid = 1'b0;
        wait_frames(r0 + 2, 200);
        if (rx_byte_q.size() >= r0 + 2) begin
            chk("b2b_gap", rx_start_q[r0 + 1] - rx_start_q[r0], FRAME);
            chk("b2b_byte0", rx_byte_q[r0], 8'h55);
            chk("b2b_byte1", rx_byte_q[r0 + 1], 8'hAA);
        end
        wait_idle(200);

        // Push in the same cycle as the end-of-stop pop.
        r0 = rx_byte_q.size();
        valid = 1'b1;
        ch = 8'h11;
        step();
        p = cyc;
        ch = 8'h22;
        step();
        ch = 8'h33;
        step();
        valid = 1'b0;
        while (cyc < p + FRAME) step();
        chk("pp_level_before", o_fifo_level, 2);
        valid = 1'b1;
        ch = 8'h44;
        step();
        valid = 1'b0;
        chk("pp_level_after", o_fifo_level, 2);
        wait_frames(r0 + 4, 300);
        for (int i = 0; i < 4; i++) begin
            if (rx_byte_q.size() > r0 + i) chk($sformatf("pp_order%0d", i), rx_byte_q[r0 + i], pp_exp[i]);
        end
        wait_idle(200);

        // Randomized traffic against the model (drops included).
        repeat (400) begin
            valid = ($urandom_range(0, 3) == 0);
            ch = 8'($urandom);
            step();
        end
        valid = 1'b0;
        wait_idle(2000);
        chk("rand_all_sent", exp_tx.size(), 0);

        // Full / overflow table.
        rst = 1'b1;
        step();
        rst = 1'b0;
        r0 = rx_byte_q.size();
        for (int i = 0; i < 6; i++) begin
            valid = tbl[i].vld;
            ch = tbl[i].dat;
            step();
            chk($sformatf("tbl%0d_level", i), o_fifo_level, tbl[i].exp_level);
            chk($sformatf("tbl%0d_ready", i), o_char_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_overflow", i), o_overflow, tbl[i].exp_ovf);
        end
        valid = 1'b0;
        wait_frames(r0 + 5, 400);
        wait_idle(300);
        chk("ovf_frame_count", rx_byte_q.size(), r0 + 5);
        for (int i = 0; i < 5; i++) begin
            if (rx_byte_q.size() > r0 + i) chk($sformatf("ovf_order%0d", i), rx_byte_q[r0 + i], tbl[i].dat);
        end
        chk("ovf_sticky", o_overflow, 1);

        // Reset during data bit 3 with three characters queued.
        r0 = rx_byte_q.size();
        valid = 1'b1;
        ch = 8'hA1;
        step();
        n = cyc;
        ch = 8'hA2;
        step();
        ch = 8'hA3;
        step();
        ch = 8'hA4;
        step();
        valid = 1'b0;
        while (cyc < n + 18) step();
        chk("mid_level_before", o_fifo_level, 3);
        rst = 1'b1;
        step();
        chk("mid_rst_tx", o_tx, 1);
        chk("mid_rst_level", o_fifo_level, 0);
        chk("mid_rst_overflow", o_overflow, 0);
        chk("mid_rst_busy", o_busy, 0);
        step();
        rst = 1'b0;
        zeros = 0;
        repeat (100) begin
            step();
            if (o_tx !== 1'b1) zeros++;
        end
        chk("mid_tx_quiet", zeros, 0);
        chk("mid_no_frames", rx_byte_q.size(), r0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d (checks=%0d)", cyc, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/saturn_debug_uart_tx.md
Name: saturn_debug_uart_tx

Overview:
Serial transmitter at the consuming end of the bus controller's debug character stream (o_char_to_send). It accepts 8-bit characters through a valid/ready handshake, buffers them in a small FIFO, and shifts them out as 8N1 UART frames on a single TX pin. It sits beside saturn_bus at the board top level. It runs on the raw i_clk, not i_clk_en, so baud timing is independent of the processor phase clock and of halt.

Parameters:
CLK_PER_BIT, 104, i_clk cycles per UART bit; legal range is 2 or more; 104 gives 12 MHz / 115200.
FIFO_AW, 4, FIFO address width; depth is 2**FIFO_AW, so 16 entries by default.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_char  in  8  character from the bus controller
i_char_valid  in  1  i_char is valid this cycle
o_char_ready  out  1  FIFO can accept a character; equals !fifo_full
o_tx  out  1  UART line; idle high
o_busy  out  1  frame in progress or FIFO not empty
o_overflow  out  1  sticky: a character was offered while the FIFO was full
o_fifo_level  out  FIFO_AW+1  number of characters currently queued

Behaviour:
- Reset (i_reset high at a clock edge) takes effect on the next edge; it wins over everything else:
  - o_tx=1, FSM=IDLE, FIFO emptied, o_fifo_level=0, o_overflow=0, o_busy=0, o_char_ready=1.
  - Reset in mid-frame aborts the frame; the line returns high immediately. No partial-frame completion.
- Push:
  - A character is written when i_char_valid && o_char_ready.
  - i_char_valid && !o_char_ready drops the character and sets o_overflow, which stays set until reset.
- Push and pop in the same cycle:
  - Level is unchanged.
  - A push is refused whenever the FIFO is full at the start of the cycle, even if a pop happens that cycle.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts CLK_PER_BIT-1 down to 0; a bit index covers 0..7.
  - IDLE: o_tx=1. If FIFO not empty: pop the head into a shift register, load the counter, go to START.
  - START: o_tx=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0], LSB first. At counter=0, shift right, increment the index, reload the counter. After bit 7, go to STOP.
  - STOP: o_tx=1 for CLK_PER_BIT cycles. At counter=0:
    - if FIFO not empty, pop and go directly to START (back-to-back frames, no extra idle cycle);
    - otherwise go to IDLE.
- Frame length is exactly 10*CLK_PER_BIT cycles.
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE makes the FIFO non-empty after N. IDLE pops at N+1, so o_tx falls at edge N+2.
- o_busy = (state != IDLE) || (level != 0).
- o_fifo_level counts queued characters only; the character in the shift register is not counted.
- FIFO pointers are FIFO_AW+1 bits wide and wrap modulo 2**(FIFO_AW+1).
  - full: the MSBs differ and the lower bits are equal.
  - empty: the pointers are equal.
- All outputs are registered except o_char_ready and o_busy, which are combinational from registers.

Decomposition:
- Package saturn_debug_pkg:
  - FSM state encoding (2-bit localparams: IDLE, START, DATA, STOP);
  - UART frame constants: DATA_BITS=8, STOP_BITS=1;
  - default CLK_PER_BIT.
- Sub-module saturn_debug_fifo (parameter FIFO_AW):
  - synchronous push/pop, data out = head, full, empty, level;
  - reused later for a debug receive path.
- Elaboration check: fail if CLK_PER_BIT < 2.

Test Plan:
- Reset idle: hold i_reset for 3 cycles, then release. Then o_tx=1, o_busy=0, o_char_ready=1, o_fifo_level=0, o_overflow=0, and o_tx stays 1 for 100 cycles.
- Single char, CLK_PER_BIT=4: push 8'h41 at edge N.
  - o_tx falls at N+2.
  - Sampling each bit window gives 0,1,0,0,0,0,0,1,0,1 (start, LSB-first data, stop).
  - Frame lasts 40 cycles; o_busy deasserts at the end.
- Back-to-back: push 8'h55 and 8'hAA on consecutive cycles. The second start bit begins exactly 40 cycles after the first, with no extra idle. The decoded bytes match.
- Full/overflow, FIFO_AW=2:
  - Push 6 characters in 6 consecutive cycles. The first is popped into the shift register, the next 4 fill the FIFO, and the 6th is dropped.
  - o_char_ready=0 and o_overflow=1.
  - Exactly 5 frames are transmitted, in order.
- Simultaneous push/pop: a push in the same cycle as the STOP-end pop keeps o_fifo_level unchanged, and ordering is preserved.
- Reset mid-frame: assert i_reset during DATA bit 3 with 3 characters queued. Next cycle o_tx=1, o_fifo_level=0, o_overflow=0, and no further frames are sent.
